// File: rtl/execute_mul_issue_sched_if.sv
// Dispatch, wakeup and issue signals between the multiply scheduler and its neighbours.
interface execute_mul_issue_sched_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic          i_enq_valid;
  logic          o_enq_ready;
  logic [3:0]    i_enq_dst_rob;
  logic [7:0]    i_enq_fid;
  logic [3:0]    i_enq_src0_rob;
  logic [3:0]    i_enq_src1_rob;
  logic          i_enq_src0_rdy;
  logic          i_enq_src1_rdy;
  logic          i_wb_valid;
  logic [3:0]    i_wb_rob;
  logic          i_stall;
  logic          i_flush;
  logic          o_issue_valid;
  logic [3:0]    o_issue_dst_rob;
  logic [7:0]    o_issue_fid;
  logic [3:0]    o_issue_src0_rob;
  logic [3:0]    o_issue_src1_rob;
  logic [CW-1:0] o_count;

  // Dispatch / writeback / multiplier side
  modport master (
    output i_enq_valid, i_enq_dst_rob, i_enq_fid, i_enq_src0_rob, i_enq_src1_rob,
           i_enq_src0_rdy, i_enq_src1_rdy, i_wb_valid, i_wb_rob, i_stall, i_flush,
    input  o_enq_ready, o_issue_valid, o_issue_dst_rob, o_issue_fid,
           o_issue_src0_rob, o_issue_src1_rob, o_count
  );

  // Scheduler side
  modport slave (
    input  i_enq_valid, i_enq_dst_rob, i_enq_fid, i_enq_src0_rob, i_enq_src1_rob,
           i_enq_src0_rdy, i_enq_src1_rdy, i_wb_valid, i_wb_rob, i_stall, i_flush,
    output o_enq_ready, o_issue_valid, o_issue_dst_rob, o_issue_fid,
           o_issue_src0_rob, o_issue_src1_rob, o_count
  );
endinterface

// File: rtl/execute_mul_issue_sched.sv
// Multiply issue scheduler: collapsing queue with operand wakeup and oldest-ready select.
module execute_mul_issue_sched #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  execute_mul_issue_sched_if.slave  bus
);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned IW = $clog2(DEPTH);

  typedef struct packed {
    logic       valid;
    logic [3:0] dst_rob;
    logic [7:0] fid;
    logic [3:0] src0_rob;
    logic       src0_rdy;
    logic [3:0] src1_rob;
    logic       src1_rdy;
  } entry_t;

  entry_t        ent_q [DEPTH];
  entry_t        ent_d [DEPTH];
  entry_t        woke  [DEPTH];
  entry_t        new_ent;
  entry_t        sel_ent;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          sel_found;
  logic [IW-1:0] sel_idx;
  logic          enq_ready_c;
  logic          issue_valid_c;
  logic          enq_fire;
  logic          issue_fire;
  logic [IW-1:0] wr_idx;

  // Stored entries with this cycle's writeback broadcast applied (visible next cycle)
  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      woke[i] = ent_q[i];
      if (ent_q[i].valid && bus.i_wb_valid) begin
        if (ent_q[i].src0_rob == bus.i_wb_rob) woke[i].src0_rdy = 1'b1;
        if (ent_q[i].src1_rob == bus.i_wb_rob) woke[i].src1_rdy = 1'b1;
      end
    end
  end

  // Oldest-ready select on registered readiness only
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (!sel_found && ent_q[i].valid && ent_q[i].src0_rdy && ent_q[i].src1_rdy) begin
        sel_found = 1'b1;
        sel_idx   = IW'(i);
      end
    end
  end

  // Incoming entry; a same-cycle writeback counts as already ready
  always_comb begin
    new_ent          = '0;
    new_ent.valid    = 1'b1;
    new_ent.dst_rob  = bus.i_enq_dst_rob;
    new_ent.fid      = bus.i_enq_fid;
    new_ent.src0_rob = bus.i_enq_src0_rob;
    new_ent.src1_rob = bus.i_enq_src1_rob;
    new_ent.src0_rdy = bus.i_enq_src0_rdy |
                       (bus.i_wb_valid & (bus.i_wb_rob == bus.i_enq_src0_rob));
    new_ent.src1_rdy = bus.i_enq_src1_rdy |
                       (bus.i_wb_valid & (bus.i_wb_rob == bus.i_enq_src1_rob));
  end

  // Handshake qualifiers; ready ignores a same-cycle issue
  always_comb begin
    enq_ready_c   = (count_q < CW'(DEPTH));
    issue_valid_c = sel_found & ~bus.i_flush;
    issue_fire    = issue_valid_c & ~bus.i_stall;
    enq_fire      = bus.i_enq_valid & enq_ready_c & ~bus.i_flush;
    wr_idx        = IW'(count_q - CW'(issue_fire));
    sel_ent       = sel_found ? ent_q[sel_idx] : ent_q[0];
  end

  // Next queue state: flush, collapse on issue, then append at the post-collapse tail
  always_comb begin
    count_d = count_q;
    for (int i = 0; i < int'(DEPTH); i++) ent_d[i] = woke[i];
    if (bus.i_flush) begin
      for (int i = 0; i < int'(DEPTH); i++) ent_d[i] = '0;
      count_d = '0;
    end else begin
      if (issue_fire) begin
        for (int i = 0; i < int'(DEPTH) - 1; i++) begin
          if (i >= int'(sel_idx)) ent_d[i] = woke[i + 1];
        end
        ent_d[DEPTH-1] = '0;
      end
      if (enq_fire) ent_d[wr_idx] = new_ent;
      count_d = count_q + CW'(enq_fire) - CW'(issue_fire);
    end
  end

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) ent_q[i] <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) ent_q[i] <= ent_d[i];
      count_q <= count_d;
    end
  end

  assign bus.o_enq_ready      = enq_ready_c;
  assign bus.o_issue_valid    = issue_valid_c;
  assign bus.o_issue_dst_rob  = sel_ent.dst_rob;
  assign bus.o_issue_fid      = sel_ent.fid;
  assign bus.o_issue_src0_rob = sel_ent.src0_rob;
  assign bus.o_issue_src1_rob = sel_ent.src1_rob;
  assign bus.o_count          = count_q;
endmodule
